// File: rtl/mram_fmap_bank.sv
`default_nettype none
// ============================================================================
// Module  : mram_fmap_bank
// Purpose : Dual-port CNN feature-map RAM with a byte-enabled read/write port A,
//           a raw/strided read-only port B and a sequential clear engine.
//           Define MRAM_FWD_EN to forward port A write data into a
//           same-address port B read.
// Revision: 1.0
// ============================================================================
module mram_fmap_bank #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned B_SHIFT    = 3,
    parameter int unsigned B_MUL      = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    output logic [DATA_WIDTH-1:0]   a_dout,
    output logic                    a_valid,
    input  logic                    b_en,
    input  logic                    b_mode,
    input  logic [31:0]             b_addr,
    output logic [DATA_WIDTH-1:0]   b_dout,
    output logic                    b_valid,
    output logic                    b_oob
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
    logic                    w_access;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [31:0]             w_b_shr;
    logic [31:0]             w_b_eff;
    logic                    w_b_oob;
    logic [ADDR_WIDTH-1:0]   w_b_idx;
    logic [DATA_WIDTH-1:0]   w_b_rd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A clear request in IDLE wins over any access in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                if (&r_cnt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_access = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state == S_CLEAR);

    assign w_b_shr = b_addr >> B_SHIFT;
    assign w_b_eff = b_mode ? (w_b_shr * 32'(B_MUL)) : b_addr;
    assign w_b_oob = (w_b_eff >> ADDR_WIDTH) != 32'd0;
    assign w_b_idx = w_b_eff[ADDR_WIDTH-1:0];

`ifdef MRAM_FWD_EN
    logic w_hit;
    assign w_hit = w_access && a_en && (a_addr == w_b_idx);
    for (genvar k = 0; k < BE_WIDTH; k++) begin : g_fwd
        assign w_b_rd[8*k +: 8] = (w_hit && a_we[k]) ? a_din[8*k +: 8]
                                                     : r_mem[w_b_idx][8*k +: 8];
    end
`else
    assign w_b_rd = r_mem[w_b_idx];
`endif

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_access && a_en) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (a_we[k]) begin
                    r_mem[a_addr][8*k +: 8] <= a_din[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_dout  <= '0;
            a_valid <= 1'b0;
            b_dout  <= '0;
            b_valid <= 1'b0;
            b_oob   <= 1'b0;
        end else begin
            a_valid <= w_access && a_en;
            b_valid <= w_access && b_en;
            if (w_access && a_en) begin
                a_dout <= r_mem[a_addr];
            end
            if (w_access && b_en) begin
                b_dout <= w_b_oob ? '0 : w_b_rd;
                b_oob  <= w_b_oob;
            end
        end
    end

endmodule
`default_nettype wire
